// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter for two masters on one single-port RAM. Grants are registered and rise one
// cycle after req. rvalid follows a read by RD_LAT cycles. A losing or preempted master holds req and waits.
module ram_port_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_lock,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_rvalid,
  input  logic          m1_req,
  input  logic          m1_lock,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_rvalid,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_wr_ena,
  output logic          ram_rd_ena,
  input  logic [DW-1:0] ram_rdata
);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              last_q, last_d;
  logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0] tag_id_q, tag_id_d;

  logic          own_req, oth_req, own_lock, own_we, access;
  logic [AW-1:0] own_addr;
  logic [DW-1:0] own_wdata;
  logic [CW-1:0] cnt_inc;
  state_t        other_st;

  // Owner-relative view of the two masters.
  always_comb begin
    own_req   = 1'b0;
    oth_req   = 1'b0;
    own_lock  = 1'b0;
    own_we    = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    other_st  = IDLE;
    case (state_q)
      OWN0: begin
        own_req   = m0_req;
        oth_req   = m1_req;
        own_lock  = m0_lock;
        own_we    = m0_we;
        own_addr  = m0_addr;
        own_wdata = m0_wdata;
        other_st  = OWN1;
      end
      OWN1: begin
        own_req   = m1_req;
        oth_req   = m0_req;
        own_lock  = m1_lock;
        own_we    = m1_we;
        own_addr  = m1_addr;
        own_wdata = m1_wdata;
        other_st  = OWN0;
      end
      default: ;
    endcase
  end

  assign access  = own_req;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_req && m1_req) begin
          state_d = last_q ? OWN0 : OWN1;
        end else if (m0_req) begin
          state_d = OWN0;
        end else if (m1_req) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (!own_req) begin
          state_d = oth_req ? other_st : IDLE;
        end else begin
          cnt_d = cnt_inc;
          // Preempt on the access that brings the count to the limit.
          if (cnt_inc == CNT_MAX && oth_req && !own_lock) begin
            state_d = other_st;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
      if (state_d == OWN0) begin
        last_d = 1'b0;
      end else if (state_d == OWN1) begin
        last_d = 1'b1;
      end
    end
  end

  always_comb begin
    ram_addr   = '0;
    ram_wdata  = '0;
    ram_wr_ena = 1'b0;
    ram_rd_ena = 1'b0;
    if (access) begin
      ram_addr   = own_addr;
      ram_wdata  = own_wdata;
      ram_wr_ena = own_we;
      ram_rd_ena = !own_we;
    end
  end

  // Read tags travel alongside the RAM pipeline so rvalid survives ownership changes.
  always_comb begin
    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = access && !own_we;
    tag_id_d[0]  = (state_q == OWN1);
    for (int i = 1; i < RD_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
    end
  end

  assign m0_gnt    = (state_q == OWN0);
  assign m1_gnt    = (state_q == OWN1);
  assign m0_rdata  = ram_rdata;
  assign m1_rdata  = ram_rdata;
  assign m0_rvalid = tag_vld_q[RD_LAT-1] && !tag_id_q[RD_LAT-1];
  assign m1_rvalid = tag_vld_q[RD_LAT-1] && tag_id_q[RD_LAT-1];

endmodule
